// File: rtl/uart_tx_ly_if.sv
// Byte producer link into the UART transmitter.
// A byte moves when pi_valid and pi_ready are both high at a rising clk edge.
// The producer holds pi_data and pi_valid steady until that edge.
// pi_ready depends only on transmitter state, never on pi_valid.
interface uart_tx_ly_if;
    logic [7:0] pi_data;
    logic       pi_valid;
    logic       pi_ready;

    modport master (output pi_data, output pi_valid, input pi_ready);
    modport slave  (input pi_data, input pi_valid, output pi_ready);
endinterface

// File: rtl/uart_tx_ly.sv
// UART transmitter: start bit, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
// The serial line is a flop that follows the FSM state by one clock.
module uart_tx_ly #(
    parameter int CLK_DIV    = 2500,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_ly_if.slave        pi,
    output logic               tx_data,
    output logic               tx_busy,
    output logic               tx_down,
    output logic [2:0]         dbg_state
);

    localparam int               CNT_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic             PAR_ODD   = (PARITY_ODD != 0);
    localparam logic             HAS_PAR   = (PARITY_EN != 0);
    localparam logic             LAST_STOP = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic             stop_q, stop_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             down_q, down_d;
    logic             accept;
    logic             bit_end;

    assign accept  = pi.pi_valid & ready_q;
    assign bit_end = (baud_q == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            down_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            down_q  <= down_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        par_d   = par_q;
        down_d  = 1'b0;
        tx_d    = 1'b1;

        // One shared baud counter times every bit of the frame.
        if (state_q != S_IDLE) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    state_d = S_START;
                    shift_d = pi.pi_data;
                    par_d   = (^pi.pi_data) ^ PAR_ODD;
                    baud_d  = '0;
                    bit_d   = '0;
                    stop_d  = 1'b0;
                end
            end
            S_START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = HAS_PAR ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                tx_d = par_q;
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (stop_q == LAST_STOP) begin
                        state_d = S_IDLE;
                        down_d  = 1'b1;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status flags are registered from the next state so they switch with it cleanly.
    assign ready_d = (state_d == S_IDLE);
    assign busy_d  = (state_d != S_IDLE);

    assign pi.pi_ready = ready_q;
    assign tx_data     = tx_q;
    assign tx_busy     = busy_q;
    assign tx_down     = down_q;
    assign dbg_state   = state_q;

    a_ready_not_busy: assert property (@(posedge clk) disable iff (rst) ready_q == ~busy_q);
    a_down_when_idle: assert property (@(posedge clk) disable iff (rst) down_q |-> ready_q);

endmodule

// File: tb/tb_uart_tx_ly.sv
// Bench for uart_tx_ly: three configurations (8N1, 8E1, 8O2) at 16 clocks per bit,
// checked cycle by cycle against a bit-position model and a mid-bit sampling receiver.
module tb_uart_tx_ly;

    localparam int DIV = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0] pdata [3];
    logic [2:0] pvalid;
    wire  [2:0] tx_w, busy_w, down_w, ready_w;
    wire  [2:0] st0, st1, st2;

    uart_tx_ly_if if0 ();
    uart_tx_ly_if if1 ();
    uart_tx_ly_if if2 ();

    assign if0.pi_data  = pdata[0];
    assign if0.pi_valid = pvalid[0];
    assign ready_w[0]   = if0.pi_ready;
    assign if1.pi_data  = pdata[1];
    assign if1.pi_valid = pvalid[1];
    assign ready_w[1]   = if1.pi_ready;
    assign if2.pi_data  = pdata[2];
    assign if2.pi_valid = pvalid[2];
    assign ready_w[2]   = if2.pi_ready;

    uart_tx_ly #(.CLK_DIV(DIV), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .pi(if0), .tx_data(tx_w[0]), .tx_busy(busy_w[0]),
        .tx_down(down_w[0]), .dbg_state(st0));
    uart_tx_ly #(.CLK_DIV(DIV), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .pi(if1), .tx_data(tx_w[1]), .tx_busy(busy_w[1]),
        .tx_down(down_w[1]), .dbg_state(st1));
    uart_tx_ly #(.CLK_DIV(DIV), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .pi(if2), .tx_data(tx_w[2]), .tx_busy(busy_w[2]),
        .tx_down(down_w[2]), .dbg_state(st2));

    int n_tests = 0;
    int n_fail  = 0;

    logic cap_line  [0:1023];
    logic cap_down  [0:1023];
    logic cap_ready [0:1023];
    logic cap_busy  [0:1023];

    logic [7:0] exp_q [$];
    logic [7:0] rx_q  [$];
    bit rx_on    = 1'b0;
    int rx_bad   = 0;
    int down_cnt = 0;

    // ---------------- reference model ----------------
    function automatic int cfg_pe(input int i);
        return (i == 0) ? 0 : 1;
    endfunction
    function automatic int cfg_po(input int i);
        return (i == 2) ? 1 : 0;
    endfunction
    function automatic int cfg_sb(input int i);
        return (i == 2) ? 2 : 1;
    endfunction
    function automatic int frame_len(input int i);
        return DIV * (9 + cfg_pe(i) + cfg_sb(i));
    endfunction
    // Line level in cycle c (1 = first cycle of the start bit) of a frame carrying b.
    function automatic logic model_line(input int i, input logic [7:0] b, input int c);
        int k;
        if (c < 1) return 1'b1;
        k = (c - 1) / DIV;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (cfg_pe(i) != 0 && k == 9) return (^b) ^ (cfg_po(i) != 0);
        return 1'b1;
    endfunction

    // ---------------- drivers / monitors ----------------
    task automatic send_accept(input int i, input logic [7:0] b, input bit keep_valid, output bit ok);
        bit r;
        ok = 1'b0;
        @(negedge clk);
        pdata[i]  = b;
        pvalid[i] = 1'b1;
        for (int budget = 0; budget < 2000 && !ok; budget++) begin
            r = ready_w[i];
            @(posedge clk);
            if (r) ok = 1'b1;
            else @(negedge clk);
        end
        #1;
        if (!keep_valid) pvalid[i] = 1'b0;
    endtask

    task automatic capture(input int i, input int n);
        for (int c = 1; c <= n; c++) begin
            @(posedge clk);
            #1;
            cap_line[c]  = tx_w[i];
            cap_down[c]  = down_w[i];
            cap_ready[c] = ready_w[i];
            cap_busy[c]  = busy_w[i];
        end
    endtask

    // Independent receiver on u0's line: falling-edge hunt, then mid-bit samples.
    initial begin : rx_proc
        logic       prev;
        logic [7:0] b;
        logic       sb, eb;
        prev = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (rx_on && prev && !tx_w[0]) begin
                repeat (DIV/2) @(posedge clk);
                #2;
                sb = tx_w[0];
                for (int k = 0; k < 8; k++) begin
                    repeat (DIV) @(posedge clk);
                    #2;
                    b[k] = tx_w[0];
                end
                repeat (DIV) @(posedge clk);
                #2;
                eb = tx_w[0];
                if (sb == 1'b0 && eb == 1'b1) rx_q.push_back(b);
                else rx_bad++;
                prev = tx_w[0];
            end else begin
                prev = tx_w[0];
            end
        end
    end

    always @(negedge clk) begin
        if (rx_on && down_w[0]) down_cnt++;
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        rst    = 1'b1;
        pvalid = 3'b000;
        for (int i = 0; i < 3; i++) pdata[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (tx_w[i] !== 1'b1) begin n_fail++; $display("FAIL reset_tx u%0d got=%b exp=1", i, tx_w[i]); end
            n_tests++;
            if (ready_w[i] !== 1'b1) begin n_fail++; $display("FAIL reset_ready u%0d got=%b exp=1", i, ready_w[i]); end
            n_tests++;
            if (busy_w[i] !== 1'b0) begin n_fail++; $display("FAIL reset_busy u%0d got=%b exp=0", i, busy_w[i]); end
            n_tests++;
            if (down_w[i] !== 1'b0) begin n_fail++; $display("FAIL reset_down u%0d got=%b exp=0", i, down_w[i]); end
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_8n1();
        bit ok;
        int L;
        int downs;
        logic [9:0] got;
        L = frame_len(0);
        send_accept(0, 8'h55, 1'b0, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL t1_accept got=timeout exp=accept"); end
        capture(0, L + 1);
        for (int k = 0; k < 10; k++) got[k] = cap_line[DIV*k + DIV/2 + 1];
        n_tests++;
        if (got !== 10'b1010101010) begin n_fail++; $display("FAIL t1_midbits got=%b exp=%b", got, 10'b1010101010); end
        downs = 0;
        for (int c = 1; c <= L + 1; c++) begin
            if (cap_down[c] === 1'b1) downs++;
            n_tests++;
            if (cap_line[c] !== model_line(0, 8'h55, c)) begin
                n_fail++; $display("FAIL t1_line c=%0d got=%b exp=%b", c, cap_line[c], model_line(0, 8'h55, c));
            end
            n_tests++;
            if (cap_ready[c] !== (c >= L)) begin
                n_fail++; $display("FAIL t1_ready c=%0d got=%b exp=%b", c, cap_ready[c], (c >= L));
            end
        end
        n_tests++;
        if (cap_down[L] !== 1'b1 || downs != 1) begin
            n_fail++; $display("FAIL t1_down at=%0d got=%b count=%0d exp=1 count=1", L, cap_down[L], downs);
        end
    endtask

    task automatic test_parity();
        bit ok;
        int L;
        int downs;
        for (int i = 1; i <= 2; i++) begin
            L = frame_len(i);
            send_accept(i, 8'h07, 1'b0, ok);
            n_tests++;
            if (!ok) begin n_fail++; $display("FAIL t2_accept u%0d got=timeout exp=accept", i); end
            capture(i, L + 1);
            n_tests++;
            if (cap_line[DIV*9 + DIV/2 + 1] !== ((i == 1) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL t2_parity u%0d got=%b exp=%b", i, cap_line[DIV*9 + DIV/2 + 1], (i == 1));
            end
            downs = 0;
            for (int c = 1; c <= L + 1; c++) begin
                if (cap_down[c] === 1'b1) downs++;
                n_tests++;
                if (cap_line[c] !== model_line(i, 8'h07, c)) begin
                    n_fail++; $display("FAIL t2_line u%0d c=%0d got=%b exp=%b", i, c, cap_line[c], model_line(i, 8'h07, c));
                end
                n_tests++;
                if (cap_busy[c] !== (c < L)) begin
                    n_fail++; $display("FAIL t2_busy u%0d c=%0d got=%b exp=%b", i, c, cap_busy[c], (c < L));
                end
            end
            n_tests++;
            if (cap_down[L] !== 1'b1 || downs != 1) begin
                n_fail++; $display("FAIL t2_down u%0d at=%0d got=%b count=%0d exp=1 count=1", i, L, cap_down[L], downs);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit   ok;
        int   L;
        int   acc2;
        bit   r_prev;
        logic e;
        L = frame_len(0);
        send_accept(0, 8'hA3, 1'b1, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL t3_accept1 got=timeout exp=accept"); end
        pdata[0] = 8'h3C;
        r_prev   = ready_w[0];
        acc2     = 0;
        for (int c = 1; c <= 2*L + 2; c++) begin
            @(posedge clk);
            if (pvalid[0] && r_prev && acc2 == 0) acc2 = c;
            #1;
            if (acc2 == c) pvalid[0] = 1'b0;
            cap_line[c]  = tx_w[0];
            cap_down[c]  = down_w[0];
            cap_ready[c] = ready_w[0];
            r_prev       = ready_w[0];
        end
        pvalid[0] = 1'b0;
        n_tests++;
        if (acc2 != L + 1) begin n_fail++; $display("FAIL t3_accept2_cycle got=%0d exp=%0d", acc2, L + 1); end
        for (int c = 1; c <= 2*L + 2; c++) begin
            e = (c <= L + 1) ? model_line(0, 8'hA3, c) : model_line(0, 8'h3C, c - (L + 1));
            n_tests++;
            if (cap_line[c] !== e) begin n_fail++; $display("FAIL t3_line c=%0d got=%b exp=%b", c, cap_line[c], e); end
            n_tests++;
            if (cap_down[c] !== (c == L || c == 2*L + 1)) begin
                n_fail++; $display("FAIL t3_down c=%0d got=%b exp=%b", c, cap_down[c], (c == L || c == 2*L + 1));
            end
            n_tests++;
            if (cap_ready[c] !== (c == L || c >= 2*L + 1)) begin
                n_fail++; $display("FAIL t3_ready c=%0d got=%b exp=%b", c, cap_ready[c], (c == L || c >= 2*L + 1));
            end
        end
    endtask

    task automatic test_busy_holdoff();
        bit         ok;
        int         L;
        logic [7:0] b;
        L = frame_len(0);
        b = 8'($urandom_range(0, 255));
        send_accept(0, b, 1'b0, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL t4_accept got=timeout exp=accept"); end
        fork
            capture(0, L + 1);
            begin
                repeat (30) @(negedge clk);
                pdata[0]  = 8'hFF;
                pvalid[0] = 1'b1;
                repeat (3) @(negedge clk);
                pvalid[0] = 1'b0;
                for (int k = 0; k < 100; k++) begin
                    @(negedge clk);
                    pdata[0] = 8'($urandom_range(0, 255));
                end
            end
        join
        for (int c = 1; c <= L + 1; c++) begin
            n_tests++;
            if (cap_line[c] !== model_line(0, b, c)) begin
                n_fail++; $display("FAIL t4_line c=%0d got=%b exp=%b", c, cap_line[c], model_line(0, b, c));
            end
            n_tests++;
            if (cap_ready[c] !== (c >= L)) begin
                n_fail++; $display("FAIL t4_ready c=%0d got=%b exp=%b", c, cap_ready[c], (c >= L));
            end
        end
        capture(0, 20);
        for (int c = 1; c <= 20; c++) begin
            n_tests++;
            if (cap_line[c] !== 1'b1 || cap_busy[c] !== 1'b0) begin
                n_fail++; $display("FAIL t4_idle_after c=%0d line=%b busy=%b exp line=1 busy=0", c, cap_line[c], cap_busy[c]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit         ok;
        int         L;
        int         downs;
        logic [7:0] b;
        L = frame_len(0);
        b = 8'($urandom_range(0, 255));
        send_accept(0, b, 1'b0, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL t5_accept got=timeout exp=accept"); end
        capture(0, 70);
        n_tests++;
        if (cap_line[70] !== b[3]) begin n_fail++; $display("FAIL t5_bit3 got=%b exp=%b", cap_line[70], b[3]); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (tx_w[0] !== 1'b1 || ready_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || down_w[0] !== 1'b0) begin
            n_fail++; $display("FAIL t5_after_rst tx=%b ready=%b busy=%b down=%b exp 1 1 0 0", tx_w[0], ready_w[0], busy_w[0], down_w[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        capture(0, 120);
        downs = 0;
        for (int c = 1; c <= 120; c++) begin
            if (cap_down[c] === 1'b1) downs++;
            n_tests++;
            if (cap_line[c] !== 1'b1) begin n_fail++; $display("FAIL t5_idle_line c=%0d got=%b exp=1", c, cap_line[c]); end
        end
        n_tests++;
        if (downs != 0) begin n_fail++; $display("FAIL t5_no_down got=%0d exp=0", downs); end
        send_accept(0, 8'h81, 1'b0, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL t5_accept2 got=timeout exp=accept"); end
        capture(0, L + 1);
        for (int c = 1; c <= L + 1; c++) begin
            n_tests++;
            if (cap_line[c] !== model_line(0, 8'h81, c)) begin
                n_fail++; $display("FAIL t5_line c=%0d got=%b exp=%b", c, cap_line[c], model_line(0, 8'h81, c));
            end
        end
        n_tests++;
        if (cap_down[L] !== 1'b1) begin n_fail++; $display("FAIL t5_down got=%b exp=1", cap_down[L]); end
    endtask

    task automatic test_random();
        bit         ok;
        int         L;
        logic [7:0] b;
        for (int n = 0; n < 8; n++) begin
            int i;
            i = 1 + (n % 2);
            L = frame_len(i);
            b = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 5)) @(negedge clk);
            send_accept(i, b, 1'b0, ok);
            n_tests++;
            if (!ok) begin n_fail++; $display("FAIL rnd_accept u%0d got=timeout exp=accept", i); end
            capture(i, L + 1);
            for (int c = 1; c <= L + 1; c++) begin
                n_tests++;
                if (cap_line[c] !== model_line(i, b, c)) begin
                    n_fail++; $display("FAIL rnd_line u%0d b=%h c=%0d got=%b exp=%b", i, b, c, cap_line[c], model_line(i, b, c));
                end
                n_tests++;
                if (cap_down[c] !== (c == L)) begin
                    n_fail++; $display("FAIL rnd_down u%0d c=%0d got=%b exp=%b", i, c, cap_down[c], (c == L));
                end
            end
        end
    endtask

    task automatic test_loopback();
        int v;
        int guard;
        bit r;
        exp_q.delete();
        rx_q.delete();
        rx_bad   = 0;
        down_cnt = 0;
        repeat (4) @(negedge clk);
        rx_on = 1'b1;
        v     = 0;
        guard = 0;
        @(negedge clk);
        pdata[0]  = 8'h00;
        pvalid[0] = 1'b1;
        while (v < 256 && guard < 60000) begin
            r = ready_w[0];
            @(posedge clk);
            guard++;
            if (r) begin
                exp_q.push_back(8'(v));
                v++;
                #1;
                if (v < 256) pdata[0] = 8'(v);
                else pvalid[0] = 1'b0;
            end
            @(negedge clk);
        end
        pvalid[0] = 1'b0;
        n_tests++;
        if (v != 256) begin n_fail++; $display("FAIL t6_accepts got=%0d exp=256", v); end
        guard = 0;
        while (rx_q.size() < exp_q.size() && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        repeat (DIV) @(negedge clk);
        rx_on = 1'b0;
        n_tests++;
        if (rx_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL t6_rx_count got=%0d exp=%0d", rx_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++) begin
            n_tests++;
            if (rx_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL t6_byte k=%0d got=%h exp=%h", k, rx_q[k], exp_q[k]); end
        end
        n_tests++;
        if (rx_bad != 0) begin n_fail++; $display("FAIL t6_framing got=%0d exp=0", rx_bad); end
        n_tests++;
        if (down_cnt != rx_q.size() || down_cnt != 256) begin
            n_fail++; $display("FAIL t6_down_count got=%0d rx=%0d exp=256", down_cnt, rx_q.size());
        end
    endtask

    initial begin : watchdog
        #1500000;
        n_fail++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin : main
        test_reset();
        test_8n1();
        test_parity();
        test_back_to_back();
        test_busy_holdoff();
        test_reset_mid();
        test_random();
        test_loopback();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
